iir_detector: RTL and testbench

IIR_DETECTOR -- requirements
Module: iir_detector

---
 rtl/iir_detector.sv | 124 ++++++++++++
 tb/tb_iir_detector.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/iir_detector.sv
// Envelope detector that follows an IIR section: peak-hold envelope with shift decay, plus ARMED/DETECT/HOLDOFF hysteresis.
// Optional event counter is compiled in only when IIR_DET_CNT_EN is defined.
module iir_detector #(
  parameter int DECAY_SHIFT = 4,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [10:0] y_in,
  input  logic               y_valid,
  input  logic [9:0]         thr_hi,
  input  logic [9:0]         thr_lo,
  input  logic [7:0]         holdoff_len,
  input  logic               clear,
  output logic [9:0]         env,
  output logic               det,
  output logic               det_pulse,
  output logic [CNT_W-1:0]   event_cnt
);

  typedef enum logic [1:0] {ARMED, DETECT, HOLDOFF} state_t;

  state_t     state, state_n;
  logic [7:0] hold_cnt, hold_n;
  logic [9:0] env_n;
  logic       pulse_n;
  logic [10:0] neg;
  logic [9:0] mag;
  logic [9:0] decayed;
  logic [9:0] env_next;

  // -1024 has no positive Q1.10 counterpart, so it saturates to 1023.
  always_comb begin
    neg = 11'(-y_in);
    if (y_in == 11'sh400)
      mag = 10'h3FF;
    else if (y_in[10])
      mag = neg[9:0];
    else
      mag = y_in[9:0];
    decayed  = env - (env >> DECAY_SHIFT);
    env_next = (mag > decayed) ? mag : decayed;
  end

  always_comb begin
    state_n = state;
    hold_n  = hold_cnt;
    env_n   = env;
    pulse_n = 1'b0;
    if (clear) begin
      state_n = ARMED;
      hold_n  = '0;
      env_n   = '0;
    end else if (y_valid) begin
      env_n = env_next;
      case (state)
        ARMED: begin
          if (env_next >= thr_hi) begin
            state_n = DETECT;
            pulse_n = 1'b1;
          end
        end
        DETECT: begin
          if (env_next < thr_lo) begin
            if (holdoff_len == 8'd0) begin
              state_n = ARMED;
              hold_n  = '0;
            end else begin
              state_n = HOLDOFF;
              hold_n  = holdoff_len;
            end
          end
        end
        HOLDOFF: begin
          // The sample that brings the counter to zero re-arms but cannot itself detect.
          if (hold_cnt <= 8'd1) begin
            state_n = ARMED;
            hold_n  = '0;
          end else begin
            hold_n = hold_cnt - 8'd1;
          end
        end
        default: begin
          state_n = ARMED;
          hold_n  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ARMED;
      hold_cnt  <= '0;
      env       <= '0;
      det_pulse <= 1'b0;
    end else begin
      state     <= state_n;
      hold_cnt  <= hold_n;
      env       <= env_n;
      det_pulse <= pulse_n;
    end
  end

  assign det = (state == DETECT);

`ifdef IIR_DET_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else if (clear)
      cnt_q <= '0;
    else if (pulse_n && (cnt_q != '1))
      cnt_q <= cnt_q + CNT_W'(1);
  end

  assign event_cnt = cnt_q;
`else
  assign event_cnt = '0;
`endif

endmodule

// File: tb/tb_iir_detector.sv
// Directed bench for iir_detector: saturation, decay, hysteresis/holdoff, clear priority, counter saturation, async reset.
module tb_iir_detector;
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic signed [10:0] y_in = '0;
  logic              y_valid = 1'b0;
  logic [9:0]        thr_hi = 10'd400;
  logic [9:0]        thr_lo = 10'd200;
  logic [7:0]        holdoff_len = 8'd3;
  logic              clear = 1'b0;
  logic [9:0]        env;
  logic              det;
  logic              det_pulse;
  logic [1:0]        event_cnt;

  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned env_m;
  int unsigned n;

  always #5 clk = ~clk;

  iir_detector #(.DECAY_SHIFT(4), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .y_in(y_in), .y_valid(y_valid),
    .thr_hi(thr_hi), .thr_lo(thr_lo), .holdoff_len(holdoff_len),
    .clear(clear), .env(env), .det(det), .det_pulse(det_pulse),
    .event_cnt(event_cnt)
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int unsigned cnt_exp(input int unsigned events);
`ifdef IIR_DET_CNT_EN
    return (events > 3) ? 3 : events;
`else
    return 0;
`endif
  endfunction

  // One valid sample; returns at the negedge after the capturing edge.
  task automatic sample(input int y);
    @(negedge clk);
    y_in = 11'(y);
    y_valid = 1'b1;
    @(negedge clk);
    y_valid = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    check("rst_env", env, 0);
    check("rst_det", det, 0);
    check("rst_pulse", det_pulse, 0);
    check("rst_cnt", event_cnt, 0);
    rst = 1'b0;

    sample(-1024);
    check("sat_env", env, 1023);
    check("sat_det", det, 1);
    check("sat_pulse", det_pulse, 1);
    check("sat_cnt", event_cnt, cnt_exp(1));
    do_clear();
    check("clr_env", env, 0);
    check("clr_det", det, 0);
    check("clr_cnt", event_cnt, 0);

    thr_hi = 10'd1023;
    thr_lo = 10'd0;
    sample(512);
    check("decay_load", env, 512);
    check("decay_nodet", det, 0);
    sample(0);
    check("decay_480", env, 480);
    sample(0);
    check("decay_450", env, 450);
    do_clear();

    thr_hi = 10'd400;
    thr_lo = 10'd200;
    holdoff_len = 8'd3;
    sample(410);
    check("det_env", env, 410);
    check("det_det", det, 1);
    check("det_pulse", det_pulse, 1);
    check("det_cnt", event_cnt, cnt_exp(1));
    @(negedge clk);
    check("pulse_once", det_pulse, 0);
    check("det_hold", det, 1);
    check("env_hold", env, 410);

    env_m = 410;
    n = 0;
    while (det && n < 40) begin
      sample(0);
      n++;
      env_m = env_m - (env_m >> 4);
      check("release_env", env, env_m);
    end
    check("release_samples", n, 12);
    check("release_env194", env, 194);
    check("release_det", det, 0);

    sample(600);
    check("hold_env", env, 600);
    check("hold_det", det, 0);
    check("hold_pulse", det_pulse, 0);
    check("hold_cnt", event_cnt, cnt_exp(1));
    sample(0);
    check("hold2_env", env, 563);
    check("hold2_det", det, 0);
    sample(0);
    check("hold3_env", env, 528);
    check("hold3_det", det, 0);
    check("hold3_pulse", det_pulse, 0);
    sample(0);
    check("rearm_env", env, 495);
    check("rearm_det", det, 1);
    check("rearm_pulse", det_pulse, 1);
    check("rearm_cnt", event_cnt, cnt_exp(2));

    @(negedge clk);
    clear = 1'b1;
    y_in = 11'sd900;
    y_valid = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    y_valid = 1'b0;
    check("cv_env", env, 0);
    check("cv_det", det, 0);
    check("cv_pulse", det_pulse, 0);
    check("cv_cnt", event_cnt, 0);
    sample(0);
    check("cv_after_det", det, 0);
    check("cv_after_env", env, 0);

    thr_lo = 10'd1023;
    holdoff_len = 8'd0;
    for (int i = 1; i <= 5; i++) begin
      sample(500);
      check("sat_loop_pulse", det_pulse, 1);
      check("sat_loop_det", det, 1);
      check("sat_loop_cnt", event_cnt, cnt_exp(i));
      sample(0);
      check("sat_loop_env", env, 469);
      check("sat_loop_rel", det, 0);
      check("sat_loop_nopulse", det_pulse, 0);
    end

    sample(500);
    check("pre_rst_det", det, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_det", det, 0);
    check("arst_env", env, 0);
    check("arst_pulse", det_pulse, 0);
    check("arst_cnt", event_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_pulse", det_pulse, 0);
    check("post_rst_det", det, 0);
    @(negedge clk);
    check("post_rst_pulse2", det_pulse, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
